// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, scale encoding and the timing bundle that
// travels alongside each pixel through the address generator.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 240;
  localparam int unsigned FB_HEIGHT = 320;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W    = 17;
  localparam int unsigned H_W       = 11;
  localparam int unsigned V_W       = 10;
  localparam int unsigned X_W       = 8;
  localparam int unsigned Y_W       = 9;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'b00,
    SCALE_2X   = 2'b01,
    SCALE_8_3X = 2'b10,
    SCALE_OFF  = 2'b11
  } scale_e;

  // Display-space window limits (exclusive) for each magnification.
  localparam int unsigned WIN_H_1X   = FB_WIDTH;
  localparam int unsigned WIN_V_1X   = FB_HEIGHT;
  localparam int unsigned WIN_H_2X   = 2 * FB_WIDTH;
  localparam int unsigned WIN_V_2X   = 2 * FB_HEIGHT;
  localparam int unsigned WIN_H_8_3X = 640;
  localparam int unsigned WIN_V_8_3X = 853;

  typedef struct packed {
    logic [1:0]     scale;
    logic [H_W-1:0] hcount;
    logic [V_W-1:0] vcount;
    logic           hsync;
    logic           vsync;
    logic           blank;
  } timing_t;

  localparam int unsigned TIMING_W = $bits(timing_t);

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register with synchronous clear; used to keep display
// timing in step with the frame-buffer read data.
module pipe_delay #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 5
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= data_in;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign data_out = stage[DEPTH-1];

endmodule

// File: rtl/frame_buff_addr_gen.sv
// Maps display hcount/vcount to a 240x320 frame-buffer read address for the
// active magnification, and delays display timing to match BRAM read data.
module frame_buff_addr_gen #(
  parameter int unsigned BRAM_LATENCY = 2,
  parameter int unsigned FB_WIDTH     = fb_pkg::FB_WIDTH,
  parameter int unsigned FB_HEIGHT    = fb_pkg::FB_HEIGHT
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [1:0]                 scale_in,
  input  logic [fb_pkg::H_W-1:0]     hcount_in,
  input  logic [fb_pkg::V_W-1:0]     vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       blank_in,
  output logic [fb_pkg::ADDR_W-1:0]  addr_out,
  output logic                       in_window_out,
  output logic [1:0]                 scale_out,
  output logic [fb_pkg::H_W-1:0]     hcount_out,
  output logic [fb_pkg::V_W-1:0]     vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       blank_out
);

  localparam int unsigned H_W    = fb_pkg::H_W;
  localparam int unsigned V_W    = fb_pkg::V_W;
  localparam int unsigned X_W    = fb_pkg::X_W;
  localparam int unsigned Y_W    = fb_pkg::Y_W;
  localparam int unsigned ADDR_W = fb_pkg::ADDR_W;
  localparam int unsigned PROD_W = 13;
  localparam int unsigned DELAY  = 3 + BRAM_LATENCY;

  localparam int unsigned H_LIM_1X   = FB_WIDTH;
  localparam int unsigned V_LIM_1X   = FB_HEIGHT;
  localparam int unsigned H_LIM_2X   = 2 * FB_WIDTH;
  localparam int unsigned V_LIM_2X   = 2 * FB_HEIGHT;
  localparam int unsigned H_LIM_8_3X = fb_pkg::WIN_H_8_3X;
  localparam int unsigned V_LIM_8_3X = fb_pkg::WIN_V_8_3X;

  fb_pkg::scale_e scale_active;
  fb_pkg::scale_e scale_eff_c;
  logic           frame_start_c;
  logic           win_c;

  logic [H_W-1:0] h1;
  logic [V_W-1:0] v1;
  fb_pkg::scale_e sc1;
  logic           win1;

  logic [PROD_W-1:0] h3_c;
  logic [PROD_W-1:0] v3_c;
  logic [X_W-1:0]    x_c;
  logic [Y_W-1:0]    y_c;

  logic [X_W-1:0] x2;
  logic [Y_W-1:0] y2;
  logic           win2;

  logic [ADDR_W-1:0] addr_c;

  fb_pkg::timing_t timing_in_c;
  fb_pkg::timing_t timing_dly;

  // A scale request on the frame-start pixel applies to that pixel itself.
  assign frame_start_c = (hcount_in == '0) && (vcount_in == '0);
  assign scale_eff_c   = frame_start_c ? fb_pkg::scale_e'(scale_in) : scale_active;

  always_comb begin
    win_c = 1'b0;
    case (scale_eff_c)
      fb_pkg::SCALE_1X:   win_c = (hcount_in < H_W'(H_LIM_1X))   && (vcount_in < V_W'(V_LIM_1X));
      fb_pkg::SCALE_2X:   win_c = (hcount_in < H_W'(H_LIM_2X))   && (vcount_in < V_W'(V_LIM_2X));
      fb_pkg::SCALE_8_3X: win_c = (hcount_in < H_W'(H_LIM_8_3X)) && (vcount_in < V_W'(V_LIM_8_3X));
      default:            win_c = 1'b0;
    endcase
  end

  // Stage 1: scale latch, registered inputs and window test.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      scale_active <= fb_pkg::SCALE_1X;
      h1           <= '0;
      v1           <= '0;
      sc1          <= fb_pkg::SCALE_1X;
      win1         <= 1'b0;
    end else begin
      if (frame_start_c) begin
        scale_active <= fb_pkg::scale_e'(scale_in);
      end
      h1   <= hcount_in;
      v1   <= vcount_in;
      sc1  <= scale_eff_c;
      win1 <= win_c;
    end
  end

  // Source coordinates; out-of-window pixels are forced to (0,0).
  always_comb begin
    h3_c = PROD_W'(h1) + PROD_W'({h1, 1'b0});
    v3_c = PROD_W'(v1) + PROD_W'({v1, 1'b0});
    x_c  = '0;
    y_c  = '0;
    if (win1) begin
      case (sc1)
        fb_pkg::SCALE_1X: begin
          x_c = X_W'(h1);
          y_c = Y_W'(v1);
        end
        fb_pkg::SCALE_2X: begin
          x_c = X_W'(h1 >> 1);
          y_c = Y_W'(v1 >> 1);
        end
        fb_pkg::SCALE_8_3X: begin
          x_c = X_W'(h3_c >> 3);
          y_c = Y_W'(v3_c >> 3);
        end
        default: begin
          x_c = '0;
          y_c = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      x2   <= '0;
      y2   <= '0;
      win2 <= 1'b0;
    end else begin
      x2   <= x_c;
      y2   <= y_c;
      win2 <= win1;
    end
  end

  // y*240 as (y<<8)-(y<<4), then add x.
  assign addr_c = ADDR_W'({y2, 8'b0}) - ADDR_W'({y2, 4'b0}) + ADDR_W'(x2);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_out      <= '0;
      in_window_out <= 1'b0;
    end else begin
      addr_out      <= win2 ? addr_c : '0;
      in_window_out <= win2;
    end
  end

  always_comb begin
    timing_in_c        = '0;
    timing_in_c.scale  = scale_eff_c;
    timing_in_c.hcount = hcount_in;
    timing_in_c.vcount = vcount_in;
    timing_in_c.hsync  = hsync_in;
    timing_in_c.vsync  = vsync_in;
    timing_in_c.blank  = blank_in;
  end

  pipe_delay #(
    .WIDTH (fb_pkg::TIMING_W),
    .DEPTH (DELAY)
  ) u_timing_delay (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .data_in  (timing_in_c),
    .data_out (timing_dly)
  );

  assign scale_out  = timing_dly.scale;
  assign hcount_out = timing_dly.hcount;
  assign vcount_out = timing_dly.vcount;
  assign hsync_out  = timing_dly.hsync;
  assign vsync_out  = timing_dly.vsync;
  assign blank_out  = timing_dly.blank;

endmodule

// File: tb/tb_frame_buff_addr_gen.sv
// Self-checking bench for frame_buff_addr_gen: per-cycle reference model plus
// directed pixels with hand-computed addresses.
module tb_frame_buff_addr_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  scale_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        hsync_in, vsync_in, blank_in;
  logic [16:0] addr_out;
  logic        in_window_out;
  logic [1:0]  scale_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, blank_out;

  always #5 clk = ~clk;

  frame_buff_addr_gen dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .scale_in      (scale_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .blank_in      (blank_in),
    .addr_out      (addr_out),
    .in_window_out (in_window_out),
    .scale_out     (scale_out),
    .hcount_out    (hcount_out),
    .vcount_out    (vcount_out),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out),
    .blank_out     (blank_out)
  );

  int n_checks = 0;
  int n_fails  = 0;
  int off_hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: history of what each clock edge sampled.
  typedef struct {
    bit rst;
    int h;
    int v;
    bit hs;
    bit vs;
    bit bl;
    int sc;
  } hist_t;

  hist_t hist[$];
  int    model_scale = 0;

  function automatic void model_addr(input int sc, input int h, input int v,
                                     output bit win, output int addr);
    int x, y;
    win = 0;
    x = 0;
    y = 0;
    case (sc)
      0: if (h < 240 && v < 320) begin win = 1; x = h;         y = v;         end
      1: if (h < 480 && v < 640) begin win = 1; x = h / 2;     y = v / 2;     end
      2: if (h < 640 && v < 853) begin win = 1; x = h * 3 / 8; y = v * 3 / 8; end
      default: win = 0;
    endcase
    addr = win ? (y * 240 + x) : 0;
  endfunction

  always @(posedge clk) begin
    hist_t e;
    e.rst = rst;
    e.h   = int'(hcount_in);
    e.v   = int'(vcount_in);
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.bl  = blank_in;
    if (rst) begin
      model_scale = 0;
    end else if (hcount_in == 0 && vcount_in == 0) begin
      model_scale = int'(scale_in);
    end
    e.sc = model_scale;
    hist.push_front(e);
    if (hist.size() > 8) void'(hist.pop_back());
  end

  always @(negedge clk) begin
    bit rst3, rst5, ew;
    int ea;
    if (hist.size() >= 5) begin
      rst3 = hist[0].rst | hist[1].rst | hist[2].rst;
      rst5 = rst3 | hist[3].rst | hist[4].rst;
      if (rst3) begin
        ew = 0;
        ea = 0;
      end else begin
        model_addr(hist[2].sc, hist[2].h, hist[2].v, ew, ea);
      end
      check("model_addr", addr_out, ea);
      check("model_in_window", in_window_out, ew);
      if (!rst3 && hist[2].sc == 3 && in_window_out) off_hits++;
      check("model_hcount", hcount_out, rst5 ? 0 : hist[4].h);
      check("model_vcount", vcount_out, rst5 ? 0 : hist[4].v);
      check("model_scale",  scale_out,  rst5 ? 0 : hist[4].sc);
      check("model_hsync",  hsync_out,  rst5 ? 0 : hist[4].hs);
      check("model_vsync",  vsync_out,  rst5 ? 0 : hist[4].vs);
      check("model_blank",  blank_out,  rst5 ? 0 : hist[4].bl);
    end
  end

  task automatic drive(input int h, input int v, input int sc,
                       input bit hs, input bit vs, input bit bl);
    @(negedge clk);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    scale_in  = 2'(sc);
    hsync_in  = hs;
    vsync_in  = vs;
    blank_in  = bl;
  endtask

  // Drive one pixel, hold it, and check the address three cycles later.
  task automatic pix(input int h, input int v, input int sc,
                     input int exp_addr, input bit exp_win, input string name);
    drive(h, v, sc, 0, 0, 0);
    repeat (3) @(negedge clk);
    check({name, "_addr"}, addr_out, exp_addr);
    check({name, "_win"}, in_window_out, exp_win);
  endtask

  int rows[8] = '{0, 1, 319, 320, 639, 640, 852, 853};

  initial begin
    rst       = 1'b1;
    scale_in  = 2'($urandom);
    hcount_in = 11'($urandom);
    vcount_in = 10'($urandom);
    hsync_in  = 1'($urandom);
    vsync_in  = 1'($urandom);
    blank_in  = 1'($urandom);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_addr",  addr_out, 0);
      check("rst_win",   in_window_out, 0);
      check("rst_scale", scale_out, 0);
      check("rst_h",     hcount_out, 0);
      check("rst_v",     vcount_out, 0);
      check("rst_sync",  {hsync_out, vsync_out, blank_out}, 0);
      scale_in  = 2'($urandom);
      hcount_in = 11'($urandom);
      vcount_in = 10'($urandom);
      hsync_in  = 1'($urandom);
      vsync_in  = 1'($urandom);
      blank_in  = 1'($urandom);
    end
    rst = 1'b0;

    drive(0, 0, 0, 0, 0, 0);
    pix(5, 2, 0, 485, 1, "s1x_5_2");
    pix(240, 0, 0, 0, 0, "s1x_240_0");
    pix(239, 319, 0, 76799, 1, "s1x_corner");
    pix(240, 319, 0, 0, 0, "s1x_past_corner");

    drive(0, 0, 1, 0, 0, 0);
    pix(479, 639, 1, 76799, 1, "s2x_corner");
    pix(480, 639, 1, 0, 0, "s2x_past_corner");
    pix(7, 3, 1, 243, 1, "s2x_7_3");

    drive(0, 0, 2, 0, 0, 0);
    pix(639, 852, 2, 76799, 1, "s83_corner");
    pix(640, 852, 2, 0, 0, "s83_past_corner");
    pix(8, 8, 2, 723, 1, "s83_8_8");

    // Mid-frame scale request is ignored until the next frame start.
    drive(0, 0, 0, 0, 0, 0);
    drive(100, 50, 1, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("midframe_scale_held", scale_out, 0);
    check("midframe_hcount", hcount_out, 100);
    drive(0, 0, 1, 0, 0, 0);
    repeat (5) @(negedge clk);
    check("framestart_scale", scale_out, 1);
    check("framestart_hcount", hcount_out, 0);

    // Mid-frame reset drops the latched scale back to 1x.
    drive(5, 2, 1, 1, 1, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_addr", addr_out, 0);
    check("midrst_hcount", hcount_out, 0);
    check("midrst_blank", blank_out, 0);
    rst = 1'b0;
    pix(5, 2, 1, 485, 1, "postrst_5_2");
    repeat (2) @(negedge clk);
    check("postrst_scale", scale_out, 0);

    for (int sc = 0; sc < 4; sc++) begin
      off_hits = 0;
      foreach (rows[r]) begin
        for (int h = 0; h < 1024; h++) begin
          drive(h, rows[r], sc, (h >= 656 && h < 752), (h % 7 == 3),
                (h >= 640 || rows[r] >= 480));
        end
      end
      repeat (6) @(negedge clk);
      if (sc == 3) check("scale_off_window_count", off_hits, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
